// File: rtl/vu_bar_renderer.sv
// rtl/vu_bar_renderer.sv - horizontal VU bar with peak-hold marker overlaid on a video raster
// Per-frame level capture, peak hold/decay, and a 2-stage pixel classify/colour pipeline.
module vu_bar_renderer #(
  parameter int BAR_TOP     = 200,
  parameter int BAR_BOT     = 280,
  parameter int GREEN_END   = 384,
  parameter int YELLOW_END  = 512,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 2,
  parameter bit V_POL       = 1'b0
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       disp_enable,
  input  logic [9:0] row,
  input  logic [9:0] column,
  input  logic [7:0] level,
  input  logic       level_valid,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  typedef enum logic [2:0] {
    C_BLANK,
    C_BG,
    C_TRACK,
    C_BAR,
    C_MARKER
  } pix_class_t;

  localparam logic [9:0] L_BAR_TOP    = 10'(BAR_TOP);
  localparam logic [9:0] L_BAR_BOT    = 10'(BAR_BOT);
  localparam logic [9:0] L_GREEN_END  = 10'(GREEN_END);
  localparam logic [9:0] L_YELLOW_END = 10'(YELLOW_END);
  localparam logic [7:0] L_HOLD       = 8'(HOLD_FRAMES);
  localparam logic [7:0] L_DECAY      = 8'(DECAY);

  logic [1:0]  r_hs;
  logic [1:0]  r_vs;
  logic [7:0]  r_acc;
  logic [7:0]  r_cur;
  logic [7:0]  r_peak;
  logic [7:0]  r_hold;
  logic        r_fs_d;
  pix_class_t  r_class;
  logic [9:0]  r_col;
  logic [3:0]  r_red;
  logic [3:0]  r_green;
  logic [3:0]  r_blue;

  logic        w_fs;
  logic [9:0]  w_bar_len;
  logic [9:0]  w_peak_len;
  logic [9:0]  w_mark_lo;
  pix_class_t  w_class;

  // r_vs[0] doubles as the registered v_sync used for frame-start detection
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_hs <= 2'b11;
      r_vs <= {2{~V_POL}};
    end else begin
      r_hs <= {r_hs[0], h_sync_in};
      r_vs <= {r_vs[0], v_sync_in};
    end
  end

  assign w_fs       = (r_vs[0] == V_POL) && (r_vs[1] != V_POL);
  assign h_sync_out = r_hs[1];
  assign v_sync_out = r_vs[1];

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_acc  <= 8'd0;
      r_cur  <= 8'd0;
      r_peak <= 8'd0;
      r_hold <= 8'd0;
      r_fs_d <= 1'b0;
    end else begin
      r_fs_d <= w_fs;
      if (w_fs) begin
        r_cur <= r_acc;
        r_acc <= level_valid ? level : 8'd0;
      end else if (level_valid && (level > r_acc)) begin
        r_acc <= level;
      end
      if (r_fs_d) begin
        if (r_cur >= r_peak) begin
          r_peak <= r_cur;
          r_hold <= L_HOLD;
        end else if (r_hold != 8'd0) begin
          r_hold <= r_hold - 8'd1;
        end else begin
          r_peak <= (r_peak > L_DECAY) ? (r_peak - L_DECAY) : 8'd0;
        end
      end
    end
  end

  // 2.5x scaling maps 0..255 onto columns 0..637
  assign w_bar_len  = {1'b0, r_cur, 1'b0} + {3'b000, r_cur[7:1]};
  assign w_peak_len = {1'b0, r_peak, 1'b0} + {3'b000, r_peak[7:1]};
  assign w_mark_lo  = (w_peak_len < 10'd2) ? 10'd0 : (w_peak_len - 10'd2);

  always_comb begin
    w_class = C_BLANK;
    if (!disp_enable) begin
      w_class = C_BLANK;
    end else if ((row < L_BAR_TOP) || (row >= L_BAR_BOT)) begin
      w_class = C_BG;
    end else if ((r_peak != 8'd0) && (column >= w_mark_lo) && (column <= w_peak_len)) begin
      w_class = C_MARKER;
    end else if (column < w_bar_len) begin
      w_class = C_BAR;
    end else begin
      w_class = C_TRACK;
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_class <= C_BLANK;
      r_col   <= 10'd0;
      r_red   <= 4'h0;
      r_green <= 4'h0;
      r_blue  <= 4'h0;
    end else begin
      r_class <= w_class;
      r_col   <= column;
      case (r_class)
        C_TRACK: {r_red, r_green, r_blue} <= 12'h222;
        C_MARKER: {r_red, r_green, r_blue} <= 12'hFFF;
        C_BAR: begin
          if (r_col < L_GREEN_END) begin
            {r_red, r_green, r_blue} <= 12'h0F0;
          end else if (r_col < L_YELLOW_END) begin
            {r_red, r_green, r_blue} <= 12'hFF0;
          end else begin
            {r_red, r_green, r_blue} <= 12'hF00;
          end
        end
        default: {r_red, r_green, r_blue} <= 12'h000;
      endcase
    end
  end

  assign red   = r_red;
  assign green = r_green;
  assign blue  = r_blue;

endmodule

// File: tb/tb_vu_bar_renderer.sv
// tb/tb_vu_bar_renderer.sv - randomized self-checking bench for vu_bar_renderer
// Frame-level reference model of level capture, peak hold and pixel colouring.
module tb_vu_bar_renderer;

  logic       pixel_clock = 1'b0;
  logic       reset = 1'b1;
  logic       h_sync_in = 1'b1;
  logic       v_sync_in = 1'b1;
  logic       disp_enable = 1'b0;
  logic [9:0] row = 10'd0;
  logic [9:0] column = 10'd0;
  logic [7:0] level = 8'd0;
  logic       level_valid = 1'b0;
  logic       h_sync_out;
  logic       v_sync_out;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  vu_bar_renderer dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .disp_enable (disp_enable),
    .row         (row),
    .column      (column),
    .level       (level),
    .level_valid (level_valid),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #5 pixel_clock = ~pixel_clock;

  int vec_count = 0;
  int err_count = 0;

  // frame-level model state
  int m_acc = 0;
  int m_cur = 0;
  int m_peak = 0;
  int m_hold = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          r;
    int          c;
  } exp_t;
  exp_t q[$];

  function automatic logic [11:0] ref_rgb(int r, int c, bit de);
    int bl;
    int pl;
    bl = 2 * m_cur + m_cur / 2;
    pl = 2 * m_peak + m_peak / 2;
    if (!de) return 12'h000;
    if (r < 200 || r >= 280) return 12'h000;
    if (m_peak > 0 && c >= pl - 2 && c <= pl) return 12'hFFF;
    if (c < bl) begin
      if (c < 384) return 12'h0F0;
      if (c < 512) return 12'hFF0;
      return 12'hF00;
    end
    return 12'h222;
  endfunction

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cur = 0;
    m_peak = 0;
    m_hold = 0;
  endtask

  task automatic model_fs(bit strobe, int lv);
    m_cur = m_acc;
    m_acc = strobe ? lv : 0;
    if (m_cur >= m_peak) begin
      m_peak = m_cur;
      m_hold = 30;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end else begin
      m_peak = (m_peak > 2) ? m_peak - 2 : 0;
    end
  endtask

  task automatic strobe(int lv);
    level = 8'(lv);
    level_valid = 1'b1;
    tick();
    level_valid = 1'b0;
    if (lv > m_acc) m_acc = lv;
  endtask

  task automatic frame_start(bit strobe_in_fs, int lv);
    disp_enable = 1'b0;
    v_sync_in = 1'b0;
    tick();
    level = 8'(lv);
    level_valid = strobe_in_fs;
    model_fs(strobe_in_fs, lv);
    tick();
    level_valid = 1'b0;
    v_sync_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_out(string name);
    exp_t e;
    e = q.pop_front();
    vec_count++;
    if ({red, green, blue, h_sync_out, v_sync_out} !== {e.rgb, e.hs, e.vs}) begin
      err_count++;
      $display("FAIL %s row=%0d col=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
               name, e.r, e.c, {red, green, blue}, h_sync_out, v_sync_out, e.rgb, e.hs, e.vs);
    end
  endtask

  // mode 0: random pixels, 1: sequential columns on fixed_row, 2: columns around the peak marker
  task automatic scan(string name, int n, int mode, int fixed_row);
    exp_t e;
    int r;
    int c;
    int pl;
    bit de;
    bit hs;
    for (int i = 0; i < n; i++) begin
      hs = 1'($urandom_range(0, 1));
      if (mode == 1) begin
        r = fixed_row;
        c = i;
        de = 1'b1;
      end else if (mode == 2) begin
        pl = 2 * m_peak + m_peak / 2;
        r = fixed_row;
        c = pl + $urandom_range(0, 8) - 5;
        if (c < 0) c = 0;
        de = 1'b1;
      end else begin
        r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(190, 290);
        c = $urandom_range(0, 1023);
        de = ($urandom_range(0, 7) != 0);
      end
      row = 10'(r);
      column = 10'(c);
      disp_enable = de;
      h_sync_in = hs;
      e.rgb = ref_rgb(r, c, de);
      e.hs = hs;
      e.vs = v_sync_in;
      e.r = r;
      e.c = c;
      q.push_back(e);
      tick();
      if (q.size() == 2) check_out(name);
    end
    disp_enable = 1'b0;
    tick();
    check_out(name);
  endtask

  task automatic test_reset();
    vec_count++;
    if ({red, green, blue} !== 12'h000) begin
      err_count++;
      $display("FAIL reset_rgb got %h want 000", {red, green, blue});
    end
    vec_count++;
    if ({h_sync_out, v_sync_out} !== 2'b11) begin
      err_count++;
      $display("FAIL reset_sync got hs=%b vs=%b want hs=1 vs=1", h_sync_out, v_sync_out);
    end
    reset = 1'b0;
    model_reset();
    tick();
    scan("reset_idle", 40, 0, 0);
  endtask

  task automatic test_level200();
    strobe(200);
    frame_start(1'b0, 0);
    scan("lvl200_row", 640, 1, 240);
    scan("lvl200_rand", 60, 0, 0);
  endtask

  task automatic test_max_of_three();
    strobe(10);
    strobe(90);
    strobe(40);
    frame_start(1'b0, 0);
    scan("max3_row", 640, 1, 240);
    scan("max3_rand", 60, 0, 0);
  endtask

  task automatic test_fs_sample();
    frame_start(1'b1, 77);
    scan("fs77_same", 60, 0, 0);
    frame_start(1'b0, 0);
    scan("fs77_next", 640, 1, 240);
  endtask

  task automatic test_level255();
    strobe(255);
    frame_start(1'b0, 0);
    scan("lvl255_row", 640, 1, 250);
    scan("lvl255_rand", 80, 0, 0);
  endtask

  task automatic test_reset_midframe();
    row = 10'd250;
    column = 10'd10;
    disp_enable = 1'b1;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    vec_count++;
    if ({red, green, blue, h_sync_out, v_sync_out} !== 15'b0000_0000_0000_1_1) begin
      err_count++;
      $display("FAIL reset_mid got rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1",
               {red, green, blue}, h_sync_out, v_sync_out);
    end
    q.delete();
    model_reset();
    tick();
    reset = 1'b0;
    scan("post_reset", 40, 0, 0);
    scan("post_reset_row", 640, 1, 250);
    strobe(60);
    frame_start(1'b0, 0);
    scan("post_reset_fs", 640, 1, 240);
  endtask

  task automatic test_small_peak();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    model_reset();
    strobe(1);
    frame_start(1'b0, 0);
    scan("small_peak", 16, 1, 240);
  endtask

  task automatic test_peak_decay();
    strobe(100);
    frame_start(1'b0, 0);
    scan("decay_set", 12, 2, 240);
    for (int f = 0; f < 85; f++) begin
      frame_start(1'b0, 0);
      scan("decay", 12, 2, 240);
    end
    scan("decay_end", 640, 1, 240);
  endtask

  initial begin
    #23;
    test_reset();
    test_level200();
    test_max_of_three();
    test_fs_sample();
    test_level255();
    test_reset_midframe();
    test_small_peak();
    test_peak_decay();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
